// File: rtl/tx_dpram_wr_arbiter_if.sv
// Write-port bundle between the three TX dpram writers and the arbiter,
// including the arbitrated dpram write port and status flags.
interface tx_dpram_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic [2:0]            req;
  logic [2:0]            we;
  logic [2:0]            last;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [2:0]            grant;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  arb_busy;
  logic                  burst_abort;
  logic                  illegal_we;
  logic                  host_promoted;

  modport master (
    output req, we, last, addr0, addr1, addr2, din0, din1, din2,
    input  grant, wea, addra, dina, arb_busy, burst_abort, illegal_we, host_promoted
  );

  modport slave (
    input  req, we, last, addr0, addr1, addr2, din0, din1, din2,
    output grant, wea, addra, dina, arb_busy, burst_abort, illegal_we, host_promoted
  );
endinterface

// File: rtl/tx_dpram_wr_arbiter.sv
// Burst-locked arbiter for the TX dpram write port: ACK/CTS > retry fix-up > host,
// with a per-grant beat watchdog and host anti-starvation promotion.
module tx_dpram_wr_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8,
  parameter int STARVE_TOP = 64
) (
  input logic                  clk,
  input logic                  rst,
  tx_dpram_wr_arbiter_if.slave bus
);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_TOP);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                state_p1;
  state_t                state_nxt;
  logic [2:0]            grant_p1;
  logic [2:0]            grant_nxt;
  logic [7:0]            beat_cnt_p1;
  logic [7:0]            beat_cnt_nxt;
  logic [7:0]            starve_cnt_p1;
  logic [7:0]            starve_cnt_nxt;
  logic                  promo_p1;
  logic                  promo_nxt;
  logic                  wr_nxt;
  logic                  abort_nxt;
  logic                  issue2;
  logic                  own_req;
  logic                  own_we;
  logic                  own_last;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] din_sel;
  logic                  wea_p1;
  logic                  abort_p1;
  logic                  illegal_p1;
  logic [ADDR_WIDTH-1:0] addra_p1;
  logic [DATA_WIDTH-1:0] dina_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] top);
    return (cnt >= top) ? top : cnt + 8'd1;
  endfunction

  // Owner view: the registered one-hot grant selects exactly one writer.
  always_comb begin
    own_req  = |(bus.req & grant_p1);
    own_we   = |(bus.we & grant_p1);
    own_last = |(bus.last & grant_p1);
    addr_sel = bus.addr0;
    din_sel  = bus.din0;
    if (grant_p1[1]) begin
      addr_sel = bus.addr1;
      din_sel  = bus.din1;
    end else if (grant_p1[2]) begin
      addr_sel = bus.addr2;
      din_sel  = bus.din2;
    end
  end

  always_comb begin
    state_nxt    = state_p1;
    grant_nxt    = grant_p1;
    beat_cnt_nxt = beat_cnt_p1;
    promo_nxt    = promo_p1;
    wr_nxt       = 1'b0;
    abort_nxt    = 1'b0;
    unique case (state_p1)
      IDLE: begin
        if (bus.req != 3'b000) begin
          state_nxt = GRANT;
          if (bus.req[0]) begin
            grant_nxt = 3'b001;
          end else if (bus.req[2] && (starve_cnt_p1 == STARVE_MAX)) begin
            grant_nxt = 3'b100;
            promo_nxt = 1'b1;
          end else if (bus.req[1]) begin
            grant_nxt = 3'b010;
          end else begin
            grant_nxt = 3'b100;
          end
        end
      end
      GRANT: begin
        if (own_we && own_last) begin
          wr_nxt       = 1'b1;
          beat_cnt_nxt = beat_cnt_p1 + 8'd1;
          state_nxt    = GAP;
          grant_nxt    = 3'b000;
          promo_nxt    = 1'b0;
        end else if (!own_req) begin
          state_nxt = GAP;
          grant_nxt = 3'b000;
          promo_nxt = 1'b0;
        end else if (own_we) begin
          wr_nxt       = 1'b1;
          beat_cnt_nxt = beat_cnt_p1 + 8'd1;
          // Watchdog: the limit beat is still written, then the grant is pulled.
          if (beat_cnt_p1 == BURST_LAST) begin
            state_nxt = GAP;
            grant_nxt = 3'b000;
            promo_nxt = 1'b0;
            abort_nxt = 1'b1;
          end
        end
      end
      GAP: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = 8'd0;
        promo_nxt    = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 3'b000;
      end
    endcase
  end

  always_comb begin
    issue2 = grant_nxt[2] & ~grant_p1[2];
    if (!bus.req[2] || issue2) begin
      starve_cnt_nxt = 8'd0;
    end else if (!grant_p1[2]) begin
      starve_cnt_nxt = sat_inc(starve_cnt_p1, STARVE_MAX);
    end else begin
      starve_cnt_nxt = starve_cnt_p1;
    end
  end

  // Stage p1: control and the dpram write port are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1      <= IDLE;
      grant_p1      <= 3'b000;
      beat_cnt_p1   <= 8'd0;
      starve_cnt_p1 <= 8'd0;
      promo_p1      <= 1'b0;
      wea_p1        <= 1'b0;
      abort_p1      <= 1'b0;
      illegal_p1    <= 1'b0;
      addra_p1      <= '0;
      dina_p1       <= '0;
    end else begin
      state_p1      <= state_nxt;
      grant_p1      <= grant_nxt;
      beat_cnt_p1   <= beat_cnt_nxt;
      starve_cnt_p1 <= starve_cnt_nxt;
      promo_p1      <= promo_nxt;
      wea_p1        <= wr_nxt;
      abort_p1      <= abort_nxt;
      illegal_p1    <= |(bus.we & ~grant_p1);
      if (wr_nxt) begin
        addra_p1 <= addr_sel;
        dina_p1  <= din_sel;
      end
    end
  end

  assign bus.grant         = grant_p1;
  assign bus.wea           = wea_p1;
  assign bus.addra         = addra_p1;
  assign bus.dina          = dina_p1;
  assign bus.arb_busy      = (state_p1 != IDLE);
  assign bus.burst_abort   = abort_p1;
  assign bus.illegal_we    = illegal_p1;
  assign bus.host_promoted = promo_p1;
endmodule

// File: tb/tb_tx_dpram_wr_arbiter.sv
// Bench for tx_dpram_wr_arbiter: directed vector table, multi-cycle corner
// sequences and random traffic against a cycle-level ownership model.
module tb_tx_dpram_wr_arbiter;
  localparam int AW         = 10;
  localparam int DW         = 64;
  localparam int MAX_BURST  = 8;
  localparam int STARVE_TOP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tx_dpram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  tx_dpram_wr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST), .STARVE_TOP(STARVE_TOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the port, whether we are in the mandatory gap,
  // how many beats the owner has written and how long the host has waited.
  bit            m_own    = 1'b0;
  logic [1:0]    m_idx    = 2'd0;
  bit            m_gap    = 1'b0;
  int            m_beats  = 0;
  int            m_starve = 0;
  bit            m_issue2 = 1'b0;
  logic [2:0]    m_cur    = 3'b000;
  logic [2:0]    e_grant  = 3'b000;
  logic          e_wea    = 1'b0;
  logic          e_busy   = 1'b0;
  logic          e_abort  = 1'b0;
  logic          e_illegal = 1'b0;
  logic          e_promo  = 1'b0;
  logic [AW-1:0] e_addra  = '0;
  logic [DW-1:0] e_dina   = '0;

  task m_write(input logic [1:0] idx);
    e_wea = 1'b1;
    case (idx)
      2'd0:    begin e_addra = bus.addr0; e_dina = bus.din0; end
      2'd1:    begin e_addra = bus.addr1; e_dina = bus.din1; end
      default: begin e_addra = bus.addr2; e_dina = bus.din2; end
    endcase
  endtask

  task m_release();
    m_own   = 1'b0;
    m_gap   = 1'b1;
    e_promo = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = 1'b0; m_gap = 1'b0; m_beats = 0; m_starve = 0;
      e_grant = 3'b000; e_wea = 1'b0; e_addra = '0; e_dina = '0;
      e_busy = 1'b0; e_abort = 1'b0; e_illegal = 1'b0; e_promo = 1'b0;
    end else begin
      m_cur     = e_grant;
      m_issue2  = 1'b0;
      e_illegal = |(bus.we & ~m_cur);
      e_wea     = 1'b0;
      e_abort   = 1'b0;
      if (m_gap) begin
        m_gap = 1'b0; m_beats = 0; e_promo = 1'b0;
      end else if (!m_own) begin
        if (bus.req != 3'b000) begin
          m_own = 1'b1;
          if (bus.req[0]) m_idx = 2'd0;
          else if (bus.req[2] && m_starve == STARVE_TOP) begin m_idx = 2'd2; e_promo = 1'b1; end
          else if (bus.req[1]) m_idx = 2'd1;
          else m_idx = 2'd2;
          m_issue2 = (m_idx == 2'd2);
        end
      end else if (bus.we[m_idx] && bus.last[m_idx]) begin
        m_write(m_idx);
        m_release();
      end else if (!bus.req[m_idx]) begin
        m_release();
      end else if (bus.we[m_idx]) begin
        m_write(m_idx);
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_release();
          e_abort = 1'b1;
        end
      end
      e_grant = m_own ? (3'b001 << m_idx) : 3'b000;
      e_busy  = m_own | m_gap;
      if (!bus.req[2] || m_issue2) m_starve = 0;
      else if (!m_cur[2] && m_starve < STARVE_TOP) m_starve++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("grant", 64'(bus.grant), 64'(e_grant));
    chk("wea", 64'(bus.wea), 64'(e_wea));
    chk("arb_busy", 64'(bus.arb_busy), 64'(e_busy));
    chk("burst_abort", 64'(bus.burst_abort), 64'(e_abort));
    chk("illegal_we", 64'(bus.illegal_we), 64'(e_illegal));
    chk("host_promoted", 64'(bus.host_promoted), 64'(e_promo));
    if (e_wea) begin
      chk("addra", 64'(bus.addra), 64'(e_addra));
      chk("dina", bus.dina, e_dina);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic clear_inputs();
    bus.req = 3'b000; bus.we = 3'b000; bus.last = 3'b000;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_wea", 64'(bus.wea), 64'd0);
    chk("rst_busy", 64'(bus.arb_busy), 64'd0);
    chk("rst_addra", 64'(bus.addra), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic [2:0]    req;
    logic [2:0]    we;
    logic [2:0]    last;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [2:0]    grant;
    logic          wea;
    logic [AW-1:0] addra;
    logic          busy;
    logic          illegal;
    logic          abort;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [2:0] req, we, last, input logic [AW-1:0] a0, a1, a2,
                         input logic [2:0] grant, input logic wea, input logic [AW-1:0] addra,
                         input logic busy, illegal, abort);
    vec_t v;
    v.req = req; v.we = we; v.last = last; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.grant = grant; v.wea = wea; v.addra = addra; v.busy = busy;
    v.illegal = illegal; v.abort = abort;
    vq.push_back(v);
  endtask

  task automatic starve_run(input bit with_req0);
    int n = 0;
    do_reset();
    bus.req = 3'b110;
    while (!(e_grant[2] || e_grant[0]) && n < 200) begin
      if (with_req0 && n == 66) bus.req[0] = 1'b1;
      step();
      n++;
      bus.we   = e_grant;
      bus.last = e_grant;
    end
    chk(with_req0 ? "starve_req0_edges" : "starve_edges", 64'(n), 64'd67);
    chk(with_req0 ? "starve_req0_grant" : "starve_grant", 64'(bus.grant),
        with_req0 ? 64'b001 : 64'b100);
    chk(with_req0 ? "starve_req0_promo" : "starve_promo", 64'(bus.host_promoted),
        with_req0 ? 64'd0 : 64'd1);
    bus.req = 3'b000; bus.we = 3'b000; bus.last = 3'b000;
    repeat (3) step();
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_wea;
    int n_abort;
    int n_ill;
    logic [AW-1:0] last_addr;

    clear_inputs();

    // Directed table: ACK burst, rogue strobe, simultaneous requests.
    add_vec(3'b001, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b001, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 3'b001, 3'b000, 10'd0, 10'd0, 10'd0, 3'b001, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 3'b001, 3'b000, 10'd1, 10'd0, 10'd0, 3'b001, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 3'b001, 3'b000, 10'd2, 10'd0, 10'd0, 3'b001, 1'b1, 10'd2, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 3'b001, 3'b000, 10'd3, 10'd0, 10'd0, 3'b001, 1'b1, 10'd3, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 3'b001, 3'b001, 10'd4, 10'd0, 10'd0, 3'b000, 1'b1, 10'd4, 1'b1, 1'b0, 1'b0);
    add_vec(3'b000, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    add_vec(3'b001, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b001, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 3'b010, 3'b000, 10'd0, 10'h3FF, 10'd0, 3'b001, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0);
    add_vec(3'b001, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b001, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b000, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b000, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    add_vec(3'b111, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b001, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b111, 3'b001, 3'b001, 10'd5, 10'd0, 10'd0, 3'b000, 1'b1, 10'd5, 1'b1, 1'b0, 1'b0);
    add_vec(3'b110, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    add_vec(3'b110, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b010, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b110, 3'b010, 3'b010, 10'd0, 10'd9, 10'd0, 3'b000, 1'b1, 10'd9, 1'b1, 1'b0, 1'b0);
    add_vec(3'b100, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    add_vec(3'b100, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b100, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    add_vec(3'b100, 3'b100, 3'b100, 10'd0, 10'd0, 10'h2A, 3'b000, 1'b1, 10'h2A, 1'b1, 1'b0, 1'b0);
    add_vec(3'b000, 3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

    do_reset();
    foreach (vq[i]) begin
      bus.req = vq[i].req; bus.we = vq[i].we; bus.last = vq[i].last;
      bus.addr0 = vq[i].a0; bus.addr1 = vq[i].a1; bus.addr2 = vq[i].a2;
      bus.din0 = {32'hD0D0_0000, 22'd0, vq[i].a0};
      bus.din1 = {32'hD1D1_0000, 22'd0, vq[i].a1};
      bus.din2 = {32'hD2D2_0000, 22'd0, vq[i].a2};
      step();
      chk($sformatf("vec%0d_grant", i), 64'(bus.grant), 64'(vq[i].grant));
      chk($sformatf("vec%0d_wea", i), 64'(bus.wea), 64'(vq[i].wea));
      if (vq[i].wea) chk($sformatf("vec%0d_addra", i), 64'(bus.addra), 64'(vq[i].addra));
      chk($sformatf("vec%0d_busy", i), 64'(bus.arb_busy), 64'(vq[i].busy));
      chk($sformatf("vec%0d_illegal", i), 64'(bus.illegal_we), 64'(vq[i].illegal));
      chk($sformatf("vec%0d_abort", i), 64'(bus.burst_abort), 64'(vq[i].abort));
    end

    // Host starvation, then the same with the ACK builder arriving at promotion time.
    starve_run(1'b0);
    starve_run(1'b1);

    // Watchdog: 10 beats without last from req1.
    do_reset();
    bus.req = 3'b010;
    step();
    n_wea = 0; n_abort = 0; n_ill = 0; last_addr = '0;
    for (int b = 0; b < 14; b++) begin
      if (b < 10) begin
        bus.we = 3'b010; bus.addr1 = AW'(b); bus.din1 = 64'(b) * 64'h0101_0101;
      end else begin
        bus.req = 3'b000; bus.we = 3'b000;
      end
      step();
      if (bus.wea) begin n_wea++; last_addr = bus.addra; end
      if (bus.burst_abort) n_abort++;
      if (bus.illegal_we) n_ill++;
    end
    chk("wd_beats_written", 64'(n_wea), 64'd8);
    chk("wd_abort_pulses", 64'(n_abort), 64'd1);
    chk("wd_illegal_pulses", 64'(n_ill), 64'd2);
    chk("wd_last_addr", 64'(last_addr), 64'd7);

    // Asynchronous reset during beat 3 of an ACK burst.
    do_reset();
    bus.req = 3'b001;
    step();
    for (int b = 0; b < 2; b++) begin
      bus.we = 3'b001; bus.addr0 = AW'(b); bus.din0 = 64'hACAC_0000 + 64'(b);
      step();
    end
    bus.addr0 = 10'd2;
    #3 rst = 1'b1;
    #1;
    chk("arst_grant", 64'(bus.grant), 64'd0);
    chk("arst_wea", 64'(bus.wea), 64'd0);
    chk("arst_busy", 64'(bus.arb_busy), 64'd0);
    check_model();
    bus.we = 3'b000;
    #2 rst = 1'b0;
    step();
    chk("arst_regrant", 64'(bus.grant), 64'b001);
    n_abort = 0;
    for (int b = 0; b < 7; b++) begin
      bus.we = 3'b001; bus.addr0 = AW'(b + 16);
      step();
      if (bus.burst_abort) n_abort++;
    end
    chk("arst_no_early_abort", 64'(n_abort), 64'd0);
    bus.addr0 = 10'd23;
    step();
    chk("arst_abort_on_8th", 64'(bus.burst_abort), 64'd1);
    bus.req = 3'b000; bus.we = 3'b000;
    repeat (3) step();

    // Random traffic against the model.
    do_reset();
    bus.req = 3'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 3'($urandom);
      bus.we = e_grant & 3'($urandom);
      if ($urandom_range(0, 19) == 0) bus.we = bus.we | 3'($urandom);
      bus.last = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000;
      bus.addr0 = AW'($urandom); bus.addr1 = AW'($urandom); bus.addr2 = AW'($urandom);
      bus.din0 = {$urandom, $urandom}; bus.din1 = {$urandom, $urandom};
      bus.din2 = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin
        #3 rst = 1'b1;
        #1 check_model();
        #1 rst = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
